// File: rtl/mips_mon_pkg.sv
// Shared types for the MIPS run monitor: stop causes, FSM states and a width helper.
package mips_mon_pkg;

   typedef enum logic [1:0] {
      NONE    = 2'd0,
      BP      = 2'd1,
      LOOP    = 2'd2,
      TIMEOUT = 2'd3
   } stop_cause_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } mon_state_t;

   // Index width for n slots, never below one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mips_run_monitor_bp_match.sv
// Breakpoint comparators with a lowest-index-wins priority encoder.
module bp_match
   import mips_mon_pkg::*;
#(
   parameter int unsigned PC_W = 32,
   parameter int unsigned N_BP = 4,
   localparam int unsigned IDX_W = idx_width(N_BP)
) (
   input  logic [PC_W-1:0]      pc,
   input  logic                 pc_valid,
   input  logic [N_BP*PC_W-1:0] bp_addr,
   input  logic [N_BP-1:0]      bp_en,
   output logic                 hit,
   output logic [IDX_W-1:0]     idx,
   output logic [N_BP-1:0]      pc_eq
);

   // Raw address compare, independent of enables and validity.
   always_comb begin
      pc_eq = '0;
      for (int i = 0; i < int'(N_BP); i++) begin
         pc_eq[i] = (pc == bp_addr[i*PC_W +: PC_W]);
      end
   end

   // Scanning downward lets the lowest matching slot be the final assignment.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int i = int'(N_BP) - 1; i >= 0; i--) begin
         if (pc_valid && bp_en[i] && pc_eq[i]) begin
            hit = 1'b1;
            idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/mips_run_monitor.sv
// Run-control monitor: stops on breakpoint, self-loop or timeout, drains, then requests a halt.
module mips_run_monitor
   import mips_mon_pkg::*;
#(
   parameter int unsigned PC_W      = 32,
   parameter int unsigned N_BP      = 4,
   parameter int unsigned DRAIN_CYC = 2,
   parameter int unsigned STUCK_LIM = 4,
   parameter int unsigned CNT_W     = 32,
   localparam int unsigned IDX_W    = idx_width(N_BP)
) (
   input  logic                 clk,
   input  logic                 start,
   input  logic [PC_W-1:0]      pc,
   input  logic                 pc_valid,
   input  logic [N_BP*PC_W-1:0] bp_addr,
   input  logic [N_BP-1:0]      bp_en,
   input  logic [CNT_W-1:0]     timeout_lim,
   input  logic                 resume,
   output logic                 halt_req,
   output logic                 done,
   output logic [1:0]           stop_cause,
   output logic [IDX_W-1:0]     hit_idx,
   output logic [PC_W-1:0]      stop_pc,
   output logic [CNT_W-1:0]     cycle_cnt,
   output logic [CNT_W-1:0]     retire_cnt
);

   localparam int unsigned STK_W = (STUCK_LIM > 0) ? $clog2(STUCK_LIM + 1) : 1;
   localparam int unsigned DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   mon_state_t       state_q, state_d;
   stop_cause_t      cause_q, cause_d;
   logic [DRN_W-1:0] drain_q, drain_d;
   logic [STK_W-1:0] stuck_q, stuck_d;
   logic [PC_W-1:0]  prev_pc_q, prev_pc_d;
   logic             prev_vld_q, prev_vld_d;
   logic [N_BP-1:0]  mask_q, mask_d;
   logic [N_BP-1:0]  slots_q, slots_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [PC_W-1:0]  spc_q, spc_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] ret_q, ret_d;
   logic             done_q, done_d;
   logic             halt_q, halt_d;

   logic             bp_hit;
   logic [IDX_W-1:0] bp_idx;
   logic [N_BP-1:0]  pc_eq;
   logic             same_pc;
   logic [STK_W-1:0] stuck_inc;
   logic             loop_hit;
   logic             tmo_hit;

   // Slots masked after a breakpoint resume are hidden from the matcher.
   bp_match #(
      .PC_W (PC_W),
      .N_BP (N_BP)
   ) u_bp_match (
      .pc       (pc),
      .pc_valid (pc_valid),
      .bp_addr  (bp_addr),
      .bp_en    (bp_en & ~mask_q),
      .hit      (bp_hit),
      .idx      (bp_idx),
      .pc_eq    (pc_eq)
   );

   assign same_pc   = prev_vld_q && (pc == prev_pc_q);
   assign stuck_inc = stuck_q + STK_W'(1);
   assign loop_hit  = (STUCK_LIM != 0) && pc_valid && same_pc &&
                      (stuck_inc == STK_W'(STUCK_LIM));
   assign tmo_hit   = (timeout_lim != '0) && ((cyc_q + CNT_W'(1)) == timeout_lim);

   always_comb begin
      state_d    = state_q;
      cause_d    = cause_q;
      drain_d    = drain_q;
      stuck_d    = stuck_q;
      prev_pc_d  = prev_pc_q;
      prev_vld_d = prev_vld_q;
      mask_d     = mask_q;
      slots_d    = slots_q;
      idx_d      = idx_q;
      spc_d      = spc_q;
      cyc_d      = cyc_q;
      ret_d      = ret_q;
      done_d     = done_q;
      halt_d     = halt_q;

      unique case (state_q)
         RUN: begin
            if (cyc_q != '1) cyc_d = cyc_q + CNT_W'(1);
            if (pc_valid && (ret_q != '1)) ret_d = ret_q + CNT_W'(1);

            if (pc_valid) begin
               prev_pc_d  = pc;
               prev_vld_d = 1'b1;
               stuck_d    = same_pc ? stuck_inc : '0;
               if ((pc_eq & mask_q) == '0) mask_d = '0;
            end

            if (bp_hit || loop_hit || tmo_hit) begin
               spc_d   = pc;
               idx_d   = bp_hit ? bp_idx : '0;
               cause_d = bp_hit ? BP : (loop_hit ? LOOP : TIMEOUT);
               slots_d = bp_hit ? (pc_eq & bp_en & ~mask_q) : '0;
               if (DRAIN_CYC == 0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  halt_d  = 1'b1;
               end else begin
                  state_d = DRAIN;
                  drain_d = DRN_W'(DRAIN_CYC - 1);
               end
            end
         end

         DRAIN: begin
            if (drain_q == '0) begin
               state_d = DONE;
               done_d  = 1'b1;
               halt_d  = 1'b1;
            end else begin
               drain_d = drain_q - DRN_W'(1);
            end
         end

         DONE: begin
            // The breakpoint slots that fired stay masked until the PC moves on.
            if (resume) begin
               state_d    = RUN;
               done_d     = 1'b0;
               halt_d     = 1'b0;
               cause_d    = NONE;
               idx_d      = '0;
               spc_d      = '0;
               stuck_d    = '0;
               prev_vld_d = 1'b0;
               mask_d     = slots_q;
               slots_d    = '0;
            end
         end

         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge start) begin
      if (!start) begin
         state_q    <= RUN;
         cause_q    <= NONE;
         drain_q    <= '0;
         stuck_q    <= '0;
         prev_pc_q  <= '0;
         prev_vld_q <= 1'b0;
         mask_q     <= '0;
         slots_q    <= '0;
         idx_q      <= '0;
         spc_q      <= '0;
         cyc_q      <= '0;
         ret_q      <= '0;
         done_q     <= 1'b0;
         halt_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cause_q    <= cause_d;
         drain_q    <= drain_d;
         stuck_q    <= stuck_d;
         prev_pc_q  <= prev_pc_d;
         prev_vld_q <= prev_vld_d;
         mask_q     <= mask_d;
         slots_q    <= slots_d;
         idx_q      <= idx_d;
         spc_q      <= spc_d;
         cyc_q      <= cyc_d;
         ret_q      <= ret_d;
         done_q     <= done_d;
         halt_q     <= halt_d;
      end
   end

   assign halt_req   = halt_q;
   assign done       = done_q;
   assign stop_cause = cause_q;
   assign hit_idx    = idx_q;
   assign stop_pc    = spc_q;
   assign cycle_cnt  = cyc_q;
   assign retire_cnt = ret_q;

endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed bench for mips_run_monitor with default parameters.
module tb_mips_run_monitor;

   logic         clk;
   logic         start;
   logic [31:0]  pc;
   logic         pc_valid;
   logic [127:0] bp_addr;
   logic [3:0]   bp_en;
   logic [31:0]  timeout_lim;
   logic         resume;
   logic         halt_req;
   logic         done;
   logic [1:0]   stop_cause;
   logic [1:0]   hit_idx;
   logic [31:0]  stop_pc;
   logic [31:0]  cycle_cnt;
   logic [31:0]  retire_cnt;

   int total;
   int bad;

   mips_run_monitor dut (
      .clk         (clk),
      .start       (start),
      .pc          (pc),
      .pc_valid    (pc_valid),
      .bp_addr     (bp_addr),
      .bp_en       (bp_en),
      .timeout_lim (timeout_lim),
      .resume      (resume),
      .halt_req    (halt_req),
      .done        (done),
      .stop_cause  (stop_cause),
      .hit_idx     (hit_idx),
      .stop_pc     (stop_pc),
      .cycle_cnt   (cycle_cnt),
      .retire_cnt  (retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      start       = 1'b0;
      pc          = '0;
      pc_valid    = 1'b0;
      bp_addr     = '0;
      bp_en       = '0;
      timeout_lim = '0;
      resume      = 1'b0;
      tick();
      tick();
      start = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0d exp=0", done); end
      total++; if (halt_req !== 1'b0) begin bad++; $display("FAIL reset_halt got=%0d exp=0", halt_req); end
      total++; if (stop_cause !== 2'd0) begin bad++; $display("FAIL reset_cause got=%0d exp=0", stop_cause); end
      total++; if (stop_pc !== 32'd0) begin bad++; $display("FAIL reset_stop_pc got=%0d exp=0", stop_pc); end
      total++; if (cycle_cnt !== 32'd0) begin bad++; $display("FAIL reset_cycle got=%0d exp=0", cycle_cnt); end
      tick();
      total++; if (cycle_cnt !== 32'd1) begin bad++; $display("FAIL first_cycle got=%0d exp=1", cycle_cnt); end
      total++; if (retire_cnt !== 32'd0) begin bad++; $display("FAIL first_retire got=%0d exp=0", retire_cnt); end
   endtask

   task automatic test_breakpoint();
      do_reset();
      bp_addr[31:0] = 32'd136;
      bp_en         = 4'b0001;
      pc_valid      = 1'b1;
      for (int k = 0; k < 35; k++) begin
         pc = 32'(4 * k);
         tick();
         if (k == 33) begin
            total++; if (stop_cause !== 2'd0) begin bad++; $display("FAIL bp_early got=%0d exp=0", stop_cause); end
         end
      end
      total++; if (stop_cause !== 2'd1) begin bad++; $display("FAIL bp_cause got=%0d exp=1", stop_cause); end
      total++; if (stop_pc !== 32'd136) begin bad++; $display("FAIL bp_stop_pc got=%0d exp=136", stop_pc); end
      total++; if (retire_cnt !== 32'd35) begin bad++; $display("FAIL bp_retire got=%0d exp=35", retire_cnt); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL bp_done_n got=%0d exp=0", done); end
      tick();
      total++; if (done !== 1'b0 || halt_req !== 1'b0) begin bad++; $display("FAIL bp_drain1 got=%0d/%0d exp=0/0", done, halt_req); end
      tick();
      total++; if (done !== 1'b1 || halt_req !== 1'b1) begin bad++; $display("FAIL bp_done got=%0d/%0d exp=1/1", done, halt_req); end
      total++; if (retire_cnt !== 32'd35 || cycle_cnt !== 32'd35) begin bad++; $display("FAIL bp_frozen got=%0d/%0d exp=35/35", retire_cnt, cycle_cnt); end
   endtask

   task automatic test_resume();
      pc     = 32'd136;
      resume = 1'b1;
      tick();
      resume = 1'b0;
      total++; if (done !== 1'b0 || halt_req !== 1'b0) begin bad++; $display("FAIL rs_clear got=%0d/%0d exp=0/0", done, halt_req); end
      total++; if (stop_cause !== 2'd0 || stop_pc !== 32'd0) begin bad++; $display("FAIL rs_cause got=%0d/%0d exp=0/0", stop_cause, stop_pc); end
      total++; if (cycle_cnt !== 32'd35) begin bad++; $display("FAIL rs_cycle got=%0d exp=35", cycle_cnt); end
      tick();
      tick();
      total++; if (stop_cause !== 2'd0) begin bad++; $display("FAIL rs_masked got=%0d exp=0", stop_cause); end
      total++; if (cycle_cnt !== 32'd37 || retire_cnt !== 32'd37) begin bad++; $display("FAIL rs_count got=%0d/%0d exp=37/37", cycle_cnt, retire_cnt); end
      pc = 32'd140;
      tick();
      pc = 32'd136;
      tick();
      total++; if (stop_cause !== 2'd1 || stop_pc !== 32'd136) begin bad++; $display("FAIL rs_rehit got=%0d/%0d exp=1/136", stop_cause, stop_pc); end
      total++; if (retire_cnt !== 32'd39) begin bad++; $display("FAIL rs_retire got=%0d exp=39", retire_cnt); end
      resume = 1'b1;
      tick();
      resume = 1'b0;
      total++; if (done !== 1'b0 || stop_cause !== 2'd1) begin bad++; $display("FAIL rs_drain_ign got=%0d/%0d exp=0/1", done, stop_cause); end
      tick();
      total++; if (done !== 1'b1 || cycle_cnt !== 32'd39) begin bad++; $display("FAIL rs_done got=%0d/%0d exp=1/39", done, cycle_cnt); end
   endtask

   task automatic test_multi_match();
      logic [31:0] a;
      do_reset();
      a = 32'd40;
      bp_addr[31:0]  = a;
      bp_addr[63:32] = a;
      bp_addr[127:96] = a;
      bp_en    = 4'b1010;
      pc_valid = 1'b1;
      for (int k = 0; k <= 10; k++) begin
         pc = 32'(4 * k);
         tick();
      end
      total++; if (stop_cause !== 2'd1 || stop_pc !== 32'd40) begin bad++; $display("FAIL mm_cause got=%0d/%0d exp=1/40", stop_cause, stop_pc); end
      total++; if (hit_idx !== 2'd1) begin bad++; $display("FAIL mm_idx got=%0d exp=1", hit_idx); end
   endtask

   task automatic test_self_loop();
      logic [31:0] seq_pc [10];
      logic        seq_v  [10];
      seq_pc = '{32'd0, 32'd4, 32'd80, 32'd80, 32'd80, 32'd12, 32'd80, 32'd80, 32'd84, 32'd88};
      seq_v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      do_reset();
      for (int k = 0; k < 10; k++) begin
         pc       = seq_pc[k];
         pc_valid = seq_v[k];
         tick();
         if (k == 4) begin
            total++; if (stop_cause !== 2'd0) begin bad++; $display("FAIL loop_early got=%0d exp=0", stop_cause); end
         end
      end
      total++; if (stop_cause !== 2'd2 || stop_pc !== 32'd80) begin bad++; $display("FAIL loop_cause got=%0d/%0d exp=2/80", stop_cause, stop_pc); end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL loop_done got=%0d exp=1", done); end
   endtask

   task automatic test_timeout();
      do_reset();
      timeout_lim = 32'd10;
      pc_valid    = 1'b1;
      for (int k = 0; k < 10; k++) begin
         pc = 32'(4 * k);
         tick();
         if (k == 8) begin
            total++; if (stop_cause !== 2'd0) begin bad++; $display("FAIL to_early got=%0d exp=0", stop_cause); end
         end
      end
      total++; if (stop_cause !== 2'd3 || stop_pc !== 32'd36) begin bad++; $display("FAIL to_cause got=%0d/%0d exp=3/36", stop_cause, stop_pc); end
      pc = 32'd40;
      tick();
      pc = 32'd44;
      tick();
      total++; if (done !== 1'b1 || cycle_cnt !== 32'd10) begin bad++; $display("FAIL to_done got=%0d/%0d exp=1/10", done, cycle_cnt); end
   endtask

   task automatic test_collision();
      do_reset();
      timeout_lim     = 32'd10;
      bp_addr[95:64]  = 32'd36;
      bp_en           = 4'b0100;
      pc_valid        = 1'b1;
      for (int k = 0; k < 10; k++) begin
         pc = 32'(4 * k);
         tick();
      end
      total++; if (stop_cause !== 2'd1 || hit_idx !== 2'd2) begin bad++; $display("FAIL col_cause got=%0d/%0d exp=1/2", stop_cause, hit_idx); end
   endtask

   task automatic test_async_reset();
      do_reset();
      bp_addr[31:0] = 32'd20;
      bp_en         = 4'b0001;
      pc_valid      = 1'b1;
      for (int k = 0; k < 6; k++) begin
         pc = 32'(4 * k);
         tick();
      end
      total++; if (stop_cause !== 2'd1 || cycle_cnt !== 32'd6) begin bad++; $display("FAIL ar_pre got=%0d/%0d exp=1/6", stop_cause, cycle_cnt); end
      #3;
      start = 1'b0;
      #1;
      total++; if (stop_cause !== 2'd0 || stop_pc !== 32'd0) begin bad++; $display("FAIL ar_cause got=%0d/%0d exp=0/0", stop_cause, stop_pc); end
      total++; if (cycle_cnt !== 32'd0 || retire_cnt !== 32'd0) begin bad++; $display("FAIL ar_cnt got=%0d/%0d exp=0/0", cycle_cnt, retire_cnt); end
      total++; if (done !== 1'b0 || halt_req !== 1'b0) begin bad++; $display("FAIL ar_done got=%0d/%0d exp=0/0", done, halt_req); end
      bp_en = '0;
      tick();
      start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         pc = 32'(4 * k);
         tick();
      end
      total++; if (cycle_cnt !== 32'd3 || retire_cnt !== 32'd3) begin bad++; $display("FAIL ar_run got=%0d/%0d exp=3/3", cycle_cnt, retire_cnt); end
      total++; if (done !== 1'b0 || stop_cause !== 2'd0) begin bad++; $display("FAIL ar_idle got=%0d/%0d exp=0/0", done, stop_cause); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_breakpoint();
      test_resume();
      test_multi_match();
      test_self_loop();
      test_timeout();
      test_collision();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mips_run_monitor.md
# mips_run_monitor

Parametrised run-control and end-of-program detector for the MIPS core. It watches the fetch PC and stops the run on a breakpoint address, a self-loop, or a cycle timeout. It then drains a fixed number of cycles so the final writebacks land, requests a core halt, and reports why and when the run stopped. It sits beside `MIPS` at the top level and replaces hand-written PC-watch loops in benches with one synthesizable block.

## Interface
- `PC_W`, 32, PC width in bits
- `N_BP`, 4, number of breakpoint comparators (1..8)
- `DRAIN_CYC`, 2, cycles between stop detection and `done`
- `STUCK_LIM`, 4, consecutive valid cycles with unchanged PC that count as a self-loop (0 disables)
- `CNT_W`, 32, width of the cycle and retire counters
- `clk`  in  1  clock; all logic on the rising edge
- `start`  in  1  asynchronous active-low reset (0 = held in reset, 1 = run)
- `pc`  in  PC_W  current fetch PC
- `pc_valid`  in  1  `pc` is a retiring fetch this cycle
- `bp_addr`  in  N_BP*PC_W  breakpoint addresses, slot i at bits [i*PC_W +: PC_W]
- `bp_en`  in  N_BP  per-slot enable
- `timeout_lim`  in  CNT_W  cycle limit; 0 disables the timeout
- `resume`  in  1  single-cycle pulse; leaves DONE and continues the run
- `halt_req`  out  1  request for the core to stop fetching
- `done`  out  1  run stopped and drain complete
- `stop_cause`  out  2  0 none, 1 breakpoint, 2 self-loop, 3 timeout
- `hit_idx`  out  $clog2(N_BP) (minimum 1)  index of the breakpoint slot that matched
- `stop_pc`  out  PC_W  PC at the detection cycle
- `cycle_cnt`  out  CNT_W  cycles spent in RUN
- `retire_cnt`  out  CNT_W  `pc_valid` cycles spent in RUN

## Operation
- States: RUN, DRAIN, DONE. Reset enters RUN. All outputs reset to 0, and the counters reset to 0.
- RUN:
  - `cycle_cnt` increments every cycle.
  - `retire_cnt` increments when `pc_valid` is high.
  - Both counters saturate at all-ones.
- Breakpoint: `pc_valid` && `bp_en[i]` && `pc == bp_addr[i]`. When several slots match, the lowest i wins.
- Self-loop:
  - A stuck counter increments on each `pc_valid` cycle whose `pc` equals the previous valid PC.
  - It clears on any other valid PC.
  - Cycles without `pc_valid` hold the stuck counter.
  - When the counter reaches `STUCK_LIM`, the self-loop stop fires.
- Timeout: `timeout_lim != 0` && `cycle_cnt + 1 == timeout_lim`. This stops the run after exactly `timeout_lim` RUN cycles.
- Priority when stop conditions occur in the same cycle: breakpoint, then self-loop, then timeout.
- On a stop:
  - `stop_cause`, `hit_idx` and `stop_pc` latch.
  - The state moves to DRAIN and the drain counter loads.
  - `halt_req` stays 0 during DRAIN so in-flight instructions retire.
- DRAIN:
  - Counts `DRAIN_CYC` cycles and does not re-detect stops.
  - Moves to DONE on the last count.
  - With `DRAIN_CYC` = 0, DRAIN is skipped and the stop goes straight to DONE.
- DONE:
  - `done` = 1 and `halt_req` = 1.
  - The counters freeze.
- `resume` in DONE:
  - Returns to RUN and clears `stop_cause`, `hit_idx`, `stop_pc` and the stuck counter.
  - The counters continue from their frozen values.
  - The PC that caused the breakpoint is masked until a different valid PC is seen, so the run does not re-stop at the same address.
- `resume` outside DONE is ignored.
- Reset asserted in any state returns immediately to RUN with all state cleared.

## Timing
- Detection is registered. A stop condition sampled at edge N shows state DRAIN, the latched cause and the latched `stop_pc` after edge N.
- `done` and `halt_req` rise after edge N + `DRAIN_CYC`.
- After a `resume` pulse sampled at edge M, `done` and `halt_req` are 0 after edge M. Counting resumes in the cycle after edge M.
- No combinational path runs from inputs to outputs.

## Structure
- Package `mips_mon_pkg` holds:
  - the `stop_cause_t` enum (NONE, BP, LOOP, TIMEOUT)
  - the `mon_state_t` enum (RUN, DRAIN, DONE)
- Sub-module `bp_match`: N_BP comparators plus a lowest-index priority encoder. It outputs `hit`, `idx`, and the `pc` compare result.
- The counters, stuck detector and FSM live in the top module.

## Test plan
- Breakpoint stop:
  - Stimulus: `bp_addr[0]`=136, `bp_en`=0001, PC steps +4 from 0 with `pc_valid`=1.
  - Required: `stop_cause`=1, `stop_pc`=136, `retire_cnt`=35, and `done` two cycles after the match.
- Multiple match:
  - Stimulus: slots 1 and 3 both hold 40.
  - Required: `hit_idx`=1.
- Self-loop:
  - Stimulus: PC holds 80 for 4 valid cycles with no breakpoint enabled.
  - Required: `stop_cause`=2 and `stop_pc`=80.
  - Also: an invalid cycle inside the run of 80s does not reset the stuck count.
- Timeout with collision:
  - Stimulus: `timeout_lim`=10.
  - Required: `cycle_cnt`=10 at DONE and `stop_cause`=3.
  - Variant: a breakpoint match in the same cycle as the timeout gives `stop_cause`=1.
- Resume:
  - Stimulus: after a breakpoint at 136, pulse `resume` while PC still reads 136.
  - Required: no re-stop until a new valid PC; the counters continue from their frozen values.
  - Also: `resume` pulsed during DRAIN has no effect.
- Async reset mid-run:
  - Stimulus: drop `start` between edges during DRAIN.
  - Required: all outputs go to 0 immediately; after `start` rises, the block is in RUN with the counters counting from 0.
